dntimer8: RTL and testbench

- 8-bit loadable down-counting timer. It is the consuming end of the counter path: it takes a start value on d_in, counts it down to zero, and raises a terminal-count pulse.
- Sits beside the up/down counter in the counter/FSM exercise set and is built in the same state-register / next-state / output-logic structure.
- Used as a programmable delay or timeout source for neighbouring FSMs.

---
 rtl/dntimer8_defs.sv | 14 +
 rtl/dntimer8_register3_ar.sv | 15 +
 rtl/dntimer8.sv | 94 +++++++++
 tb/tb_dntimer8.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/dntimer8_defs.sv
// Shared state encoding for the dntimer8 loadable down-counting timer.
package dntimer8_defs;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    RUN   = 3'b010,
    PAUSE = 3'b011,
    DONE  = 3'b100
  } state_t;

endpackage

// File: rtl/dntimer8_register3_ar.sv
// 3-bit state register with asynchronous active-high reset to 000.
module register3_ar (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] d,
  output logic [2:0] q
);

  // NOTE: sequential state uses <= so every flop samples pre-edge values, avoiding races between blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 3'b000;
    else       q <= d;
  end

endmodule

// File: rtl/dntimer8.sv
// Loadable down-counting timer: counts a loaded start value to zero and pulses tc in DONE.
module dntimer8
  import dntimer8_defs::*;
#(
  parameter int WIDTH       = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               en,
  input  logic [WIDTH-1:0]   d_in,
  output logic [WIDTH-1:0]   d_out,
  output logic               tc,
  output logic               busy,
  output logic [STATE_W-1:0] o_state
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [WIDTH-1:0]   count;
  logic [WIDTH-1:0]   count_nxt;
  logic [WIDTH-1:0]   reload_reg;
  logic [WIDTH-1:0]   reload_nxt;

  register3_ar u_state_reg (
    .clk   (clk),
    .reset (reset),
    .d     (state_nxt),
    .q     (state)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a value unassigned (no latch).
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    if (load) begin
      state_nxt  = LOAD;
      count_nxt  = d_in;
      reload_nxt = d_in;
    end else begin
      case (state)
        IDLE: begin
          if (en && count != '0) state_nxt = RUN;
        end
        LOAD: begin
          state_nxt = en ? RUN : PAUSE;
        end
        RUN: begin
          if (!en) begin
            state_nxt = PAUSE;
          end else if (count == '0) begin
            // Only reachable after loading 0; never wrap below zero.
            state_nxt = DONE;
          end else if (count == WIDTH'(1)) begin
            count_nxt = '0;
            state_nxt = DONE;
          end else begin
            count_nxt = count - WIDTH'(1);
          end
        end
        PAUSE: begin
          if (en) state_nxt = RUN;
        end
        DONE: begin
          if (AUTO_RELOAD && reload_reg != '0) begin
            count_nxt = reload_reg;
            state_nxt = en ? RUN : PAUSE;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      reload_reg <= '0;
    end else begin
      count      <= count_nxt;
      reload_reg <= reload_nxt;
    end
  end

  assign d_out   = count;
  assign tc      = (state == DONE);
  assign busy    = (state == LOAD) || (state == RUN) || (state == PAUSE);
  assign o_state = state;

endmodule

// File: tb/tb_dntimer8.sv
// Self-checking bench for dntimer8: vector table plus hand-written reset and auto-reload sequences.
module tb_dntimer8;

  typedef struct {
    logic       sel;
    logic       load;
    logic       en;
    logic [7:0] d;
    logic [2:0] st;
    logic [7:0] dout;
  } vec_t;

  typedef struct {
    logic       sel;
    logic [2:0] st;
    logic [7:0] dout;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load0 = 1'b0, en0 = 1'b0;
  logic       load1 = 1'b0, en1 = 1'b0;
  logic [7:0] d_in0 = '0, d_in1 = '0;
  logic [7:0] d_out0, d_out1;
  logic       tc0, tc1, busy0, busy1;
  logic [2:0] st0, st1;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  dntimer8 #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load(load0), .en(en0), .d_in(d_in0),
    .d_out(d_out0), .tc(tc0), .busy(busy0), .o_state(st0)
  );

  dntimer8 #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .en(en1), .d_in(d_in1),
    .d_out(d_out1), .tc(tc1), .busy(busy1), .o_state(st1)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input logic sel,
                               input logic [2:0] st, input logic [7:0] dout);
    logic       exp_tc;
    logic       exp_busy;
    exp_tc   = (st == 3'b100);
    exp_busy = (st == 3'b001) || (st == 3'b010) || (st == 3'b011);
    if (!sel) begin
      check({tag, " state"}, int'(st0), int'(st));
      check({tag, " d_out"}, int'(d_out0), int'(dout));
      check({tag, " tc"}, int'(tc0), int'(exp_tc));
      check({tag, " busy"}, int'(busy0), int'(exp_busy));
    end else begin
      check({tag, " state"}, int'(st1), int'(st));
      check({tag, " d_out"}, int'(d_out1), int'(dout));
      check({tag, " tc"}, int'(tc1), int'(exp_tc));
      check({tag, " busy"}, int'(busy1), int'(exp_busy));
    end
  endtask

  // Drive one vector on the falling edge, record its expectation, compare just after the rising edge.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    if (!v.sel) begin load0 = v.load; en0 = v.en; d_in0 = v.d; end
    else        begin load1 = v.load; en1 = v.en; d_in1 = v.d; end
    sb.push_back('{sel: v.sel, st: v.st, dout: v.dout});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_outputs(tag, e.sel, e.st, e.dout);
    end
  endtask

  task automatic add(input logic sel, input logic l, input logic e, input logic [7:0] d,
                     input logic [2:0] st, input logic [7:0] dout);
    tbl.push_back('{sel: sel, load: l, en: e, d: d, st: st, dout: dout});
  endtask

  localparam logic [2:0] S_IDLE = 3'b000, S_LOAD = 3'b001, S_RUN = 3'b010,
                         S_PAUSE = 3'b011, S_DONE = 3'b100;

  initial begin
    // Basic countdown of 3
    add(0, 1, 1, 8'h03, S_LOAD, 8'h03);
    add(0, 0, 1, 8'h00, S_RUN, 8'h03);
    add(0, 0, 1, 8'h00, S_RUN, 8'h02);
    add(0, 0, 1, 8'h00, S_RUN, 8'h01);
    add(0, 0, 1, 8'h00, S_DONE, 8'h00);
    add(0, 0, 1, 8'h00, S_IDLE, 8'h00);
    add(0, 0, 1, 8'h00, S_IDLE, 8'h00);
    // Pause at d_out=2 for three en-low edges
    add(0, 1, 1, 8'h04, S_LOAD, 8'h04);
    add(0, 0, 1, 8'h00, S_RUN, 8'h04);
    add(0, 0, 1, 8'h00, S_RUN, 8'h03);
    add(0, 0, 1, 8'h00, S_RUN, 8'h02);
    add(0, 0, 0, 8'h00, S_PAUSE, 8'h02);
    add(0, 0, 0, 8'h00, S_PAUSE, 8'h02);
    add(0, 0, 0, 8'h00, S_PAUSE, 8'h02);
    add(0, 0, 1, 8'h00, S_RUN, 8'h02);
    add(0, 0, 1, 8'h00, S_RUN, 8'h01);
    add(0, 0, 1, 8'h00, S_DONE, 8'h00);
    add(0, 0, 0, 8'h00, S_IDLE, 8'h00);
    // Load zero
    add(0, 1, 1, 8'h00, S_LOAD, 8'h00);
    add(0, 0, 1, 8'h00, S_RUN, 8'h00);
    add(0, 0, 1, 8'h00, S_DONE, 8'h00);
    add(0, 0, 1, 8'h00, S_IDLE, 8'h00);
    add(0, 0, 1, 8'h00, S_IDLE, 8'h00);
    // Reload priority mid-count
    add(0, 1, 1, 8'h10, S_LOAD, 8'h10);
    add(0, 0, 1, 8'h00, S_RUN, 8'h10);
    for (int i = 15; i >= 10; i--) add(0, 0, 1, 8'h00, S_RUN, 8'(i));
    add(0, 1, 1, 8'h02, S_LOAD, 8'h02);
    add(0, 0, 1, 8'h00, S_RUN, 8'h02);
    add(0, 0, 1, 8'h00, S_RUN, 8'h01);
    add(0, 0, 1, 8'h00, S_DONE, 8'h00);
    add(0, 0, 1, 8'h00, S_IDLE, 8'h00);
    // LOAD with en low goes to PAUSE; load overrides PAUSE
    add(0, 1, 0, 8'h07, S_LOAD, 8'h07);
    add(0, 0, 0, 8'h00, S_PAUSE, 8'h07);
    add(0, 1, 1, 8'h01, S_LOAD, 8'h01);
    add(0, 0, 1, 8'h00, S_RUN, 8'h01);
    add(0, 0, 1, 8'h00, S_DONE, 8'h00);
    add(0, 0, 1, 8'h00, S_IDLE, 8'h00);
    // Auto-reload of 2: tc every three cycles, then PAUSE when en low during DONE
    add(1, 1, 1, 8'h02, S_LOAD, 8'h02);
    add(1, 0, 1, 8'h00, S_RUN, 8'h02);
    for (int r = 0; r < 3; r++) begin
      add(1, 0, 1, 8'h00, S_RUN, 8'h01);
      add(1, 0, 1, 8'h00, S_DONE, 8'h00);
      add(1, 0, 1, 8'h00, S_RUN, 8'h02);
    end
    add(1, 0, 1, 8'h00, S_RUN, 8'h01);
    add(1, 0, 1, 8'h00, S_DONE, 8'h00);
    add(1, 0, 0, 8'h00, S_PAUSE, 8'h02);
    add(1, 0, 1, 8'h00, S_RUN, 8'h02);
    add(1, 0, 1, 8'h00, S_RUN, 8'h01);
    add(1, 0, 1, 8'h00, S_DONE, 8'h00);
    // Auto-reload with a zero reload value falls back to IDLE
    add(1, 1, 1, 8'h00, S_LOAD, 8'h00);
    add(1, 0, 1, 8'h00, S_RUN, 8'h00);
    add(1, 0, 1, 8'h00, S_DONE, 8'h00);
    add(1, 0, 1, 8'h00, S_IDLE, 8'h00);

    // Reset state
    #12;
    check_outputs("reset0", 1'b0, S_IDLE, 8'h00);
    check_outputs("reset1", 1'b1, S_IDLE, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset mid-count after two decrements
    apply("rst_seq ld", '{sel: 0, load: 1, en: 1, d: 8'h05, st: S_LOAD, dout: 8'h05});
    apply("rst_seq r5", '{sel: 0, load: 0, en: 1, d: 8'h00, st: S_RUN, dout: 8'h05});
    apply("rst_seq r4", '{sel: 0, load: 0, en: 1, d: 8'h00, st: S_RUN, dout: 8'h04});
    apply("rst_seq r3", '{sel: 0, load: 0, en: 1, d: 8'h00, st: S_RUN, dout: 8'h03});
    #1;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", 1'b0, S_IDLE, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    en0 = 1'b1;
    // Reload register must also have cleared: IDLE with count 0 stays put
    @(posedge clk);
    #1;
    check_outputs("post_reset", 1'b0, S_IDLE, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
